// File: rtl/uart_rx_core.sv
// UART receive core: oversampled start/data/parity/stop de-serialiser with error flags.
// Define RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around the bit centre.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PRSC_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRSC_WIDTH-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state, state_next;
  logic [PRSC_WIDTH-1:0]   edge_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   shift;
  logic [PRSC_WIDTH-1:0]   ticks, half, last_tick, samp_pt;
  logic                    samp_tick, end_tick, exit_tick, bit_val;

  // Unsupported prescale values fall back to 8 ticks per bit.
  always_comb begin
    ticks = PRSC_WIDTH'(8);
    if (Prescale == PRSC_WIDTH'(16)) ticks = PRSC_WIDTH'(16);
    if (Prescale == PRSC_WIDTH'(32)) ticks = PRSC_WIDTH'(32);
  end

  assign half      = ticks >> 1;
  assign last_tick = ticks - PRSC_WIDTH'(1);

`ifdef RX_MAJORITY_VOTE_EN
  logic s_early, s_mid;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else begin
      if (edge_cnt == half - PRSC_WIDTH'(1)) s_early <= RX_IN;
      if (edge_cnt == half)                  s_mid   <= RX_IN;
    end
  end

  // Third sample is taken live at S+1, where all bit actions happen.
  assign samp_pt = half + PRSC_WIDTH'(1);
  assign bit_val = (s_early & s_mid) | (s_early & RX_IN) | (s_mid & RX_IN);
`else
  assign samp_pt = half;
  assign bit_val = RX_IN;
`endif

  assign samp_tick = (edge_cnt == samp_pt);
  assign end_tick  = (edge_cnt == last_tick);
  assign exit_tick = (edge_cnt == samp_pt + PRSC_WIDTH'(1));

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:   if (!RX_IN) state_next = START;
      START:  begin
        if (samp_tick && bit_val) state_next = IDLE;
        else if (end_tick)        state_next = DATA;
      end
      DATA:   if (end_tick && bit_cnt == BW'(DATA_WIDTH - 1))
                state_next = PAR_EN ? PARITY : STOP;
      PARITY: if (end_tick) state_next = STOP;
      // Leave early so the rest of the stop bit is spent watching for a new start edge.
      STOP:   if (exit_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      state      <= state_next;
      data_valid <= 1'b0;

      if (state == IDLE || state_next == IDLE || end_tick) edge_cnt <= '0;
      else                                                 edge_cnt <= edge_cnt + PRSC_WIDTH'(1);

      if (state != DATA) bit_cnt <= '0;
      else if (end_tick) bit_cnt <= bit_cnt + BW'(1);

      if (state == DATA && samp_tick) shift <= {bit_val, shift[DATA_WIDTH-1:1]};

      if (state == IDLE && !RX_IN) begin
        par_err <= 1'b0;
        stp_err <= 1'b0;
      end

      if (state == PARITY && samp_tick)
        par_err <= (bit_val != (^shift ^ PAR_TYP));

      if (state == STOP && samp_tick) begin
        stp_err <= ~bit_val;
        if (bit_val && !par_err) begin
          P_DATA     <= shift;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus randomised frames
// checked against a frame-level outcome model.
module tb_uart_rx_core;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err, busy;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] dv_q[$];
  int         dv_run = 0;
  int         dv_long = 0;
  logic [7:0] exp_pdata = 8'h00;
  logic       seen_busy, seen_pe, seen_se;

  uart_rx_core #(.DATA_WIDTH(8), .PRSC_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Collect every data_valid strobe with the data presented alongside it.
  always @(negedge CLK) begin
    if (data_valid) begin
      dv_q.push_back(P_DATA);
      dv_run = dv_run + 1;
      if (dv_run > 1) dv_long = dv_long + 1;
    end else begin
      dv_run = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int eff_ticks(input logic [5:0] p);
    return (p == 6'd16 || p == 6'd32) ? int'(p) : 8;
  endfunction

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Serialise one frame; capture busy mid-start-bit and flags just after the stop decision.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic [5:0] psc, input logic bad_par, input logic stop_val);
    int   p;
    logic bl[$];
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    Prescale = psc;
    p        = eff_ticks(psc);
    seen_busy = 1'b0;
    seen_pe   = 1'b0;
    seen_se   = 1'b0;
    bl = {1'b0};
    for (int i = 0; i < 8; i++) bl.push_back(d[i]);
    if (pen) bl.push_back(^d ^ ptyp ^ bad_par);
    bl.push_back(stop_val);
    for (int k = 0; k < bl.size(); k++) begin
      RX_IN = bl[k];
      for (int i = 0; i < p; i++) begin
        @(negedge CLK);
        if (k == 0 && i == p / 2) seen_busy = busy;
        if (k == bl.size() - 1 && i == p / 2 + 2) begin
          seen_pe = par_err;
          seen_se = stp_err;
        end
      end
    end
    RX_IN = 1'b1;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d, input logic pen,
                             input logic ptyp, input logic [5:0] psc, input logic bad_par,
                             input logic stop_val, input int q_before);
    logic exp_pe, exp_se, good;
    int   got;
    exp_pe = pen & bad_par;
    exp_se = ~stop_val;
    good   = ~exp_pe & ~exp_se;
    got    = dv_q.size() - q_before;
    chk({tag, "_busy"}, 32'(seen_busy), 32'd1);
    chk({tag, "_par_err"}, 32'(seen_pe), 32'(exp_pe));
    chk({tag, "_stp_err"}, 32'(seen_se), 32'(exp_se));
    chk({tag, "_dv_count"}, 32'(got), good ? 32'd1 : 32'd0);
    if (good) begin
      exp_pdata = d;
      if (got > 0) chk({tag, "_dv_data"}, 32'(dv_q[q_before]), 32'(d));
    end
    chk({tag, "_p_data"}, 32'(P_DATA), 32'(exp_pdata));
    $display("frame %s: data=%02h psc=%0d pen=%0b ptyp=%0b bad_par=%0b stop=%0b -> dv=%0d P_DATA=%02h pe=%0b se=%0b",
             tag, d, psc, pen, ptyp, bad_par, stop_val, got, P_DATA, seen_pe, seen_se);
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic pen, input logic ptyp,
                       input logic [5:0] psc, input logic bad_par, input logic stop_val);
    int q0;
    q0 = dv_q.size();
    send_frame(d, pen, ptyp, psc, bad_par, stop_val);
    check_frame(tag, d, pen, ptyp, psc, bad_par, stop_val, q0);
    idle(2 * eff_ticks(psc));
  endtask

  initial begin
    logic [5:0] psc_tab[5];
    logic [7:0] rd;
    logic       rpen, rptyp, rbad, rstop;
    logic [5:0] rpsc;
    logic       g_busy;
    int         q0;
    psc_tab = '{6'd8, 6'd16, 6'd32, 6'd12, 6'd8};

    repeat (3) @(negedge CLK);
    chk("reset_p_data", 32'(P_DATA), 32'h0);
    chk("reset_dv", 32'(data_valid), 32'h0);
    chk("reset_flags", {30'd0, par_err, stp_err}, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    RST = 1'b1;
    idle(10);

    frame("p8_a5", 8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
    frame("p16_3c_good", 8'h3C, 1'b1, 1'b0, 6'd16, 1'b0, 1'b1);
    frame("p16_3c_badpar", 8'h3C, 1'b1, 1'b0, 6'd16, 1'b1, 1'b1);
    frame("p32_00_stop0", 8'h00, 1'b1, 1'b1, 6'd32, 1'b0, 1'b0);

    // Short low glitch on the line must be rejected as a false start.
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    q0 = dv_q.size();
    RX_IN = 1'b0;
    @(negedge CLK);
    g_busy = busy;
    @(negedge CLK);
    RX_IN = 1'b1;
    repeat (20) @(negedge CLK);
    chk("glitch_busy_start", 32'(g_busy), 32'd1);
    chk("glitch_busy_end", 32'(busy), 32'd0);
    chk("glitch_flags", {30'd0, par_err, stp_err}, 32'h0);
    chk("glitch_dv", 32'(dv_q.size() - q0), 32'd0);
    $display("frame glitch: busy_start=%0b busy_end=%0b pe=%0b se=%0b", g_busy, busy, par_err, stp_err);

    // Back-to-back frames with no idle gap.
    q0 = dv_q.size();
    send_frame(8'h55, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
    idle(16);
    chk("b2b_dv_count", 32'(dv_q.size() - q0), 32'd2);
    if (dv_q.size() - q0 == 2) begin
      chk("b2b_first", 32'(dv_q[q0]), 32'h55);
      chk("b2b_second", 32'(dv_q[q0 + 1]), 32'hAA);
    end
    exp_pdata = 8'hAA;
    chk("b2b_p_data", 32'(P_DATA), 32'hAA);
    $display("frame b2b: dv=%0d P_DATA=%02h", dv_q.size() - q0, P_DATA);

    // Reset asserted in the middle of data bit 4.
    PAR_EN   = 1'b0;
    Prescale = 6'd8;
    rd = 8'hF0;
    RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    for (int b = 0; b < 4; b++) begin
      RX_IN = rd[b];
      repeat (8) @(negedge CLK);
    end
    RX_IN = rd[4];
    repeat (3) @(negedge CLK);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    chk("midreset_p_data", 32'(P_DATA), 32'h0);
    chk("midreset_dv_flags", {29'd0, data_valid, par_err, stp_err}, 32'h0);
    chk("midreset_busy", 32'(busy), 32'd0);
    $display("frame midreset: P_DATA=%02h busy=%0b", P_DATA, busy);
    exp_pdata = 8'h00;
    RST = 1'b1;
    idle(16);
    frame("after_reset_81", 8'h81, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);

    for (int n = 0; n < 14; n++) begin
      rd    = 8'($urandom);
      rpsc  = psc_tab[$urandom_range(0, 4)];
      rpen  = 1'($urandom_range(0, 1));
      rptyp = 1'($urandom_range(0, 1));
      rbad  = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 4) != 0);
      frame($sformatf("rnd%0d", n), rd, rpen, rptyp, rpsc, rbad, rstop);
    end

    chk("dv_single_cycle", 32'(dv_long), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
